// File: rtl/cmac_reg_group_ctrl_if.sv
// Bus bundle between the CMAC single register block / software side and the
// ping-pong register-group scheduler.
// Build option: CMAC_GRP_PERF_EN adds the perf_cycles readback field.
interface cmac_reg_group_ctrl_if;

  logic        producer;
  logic        op_en_wr;
  logic        op_en_wdata;
  logic        dp_done;

  logic        dp_op_start;
  logic        dp_busy;
  logic        consumer;
  logic [1:0]  status_0;
  logic [1:0]  status_1;
  logic        op_en_0;
  logic        op_en_1;
  logic [1:0]  done_intr;
  logic        err;
`ifdef CMAC_GRP_PERF_EN
  logic [31:0] perf_cycles;
`endif

`ifdef CMAC_GRP_PERF_EN
  modport master (
    output producer, op_en_wr, op_en_wdata, dp_done,
    input  dp_op_start, dp_busy, consumer, status_0, status_1,
    input  op_en_0, op_en_1, done_intr, err, perf_cycles
  );

  modport slave (
    input  producer, op_en_wr, op_en_wdata, dp_done,
    output dp_op_start, dp_busy, consumer, status_0, status_1,
    output op_en_0, op_en_1, done_intr, err, perf_cycles
  );
`else
  modport master (
    output producer, op_en_wr, op_en_wdata, dp_done,
    input  dp_op_start, dp_busy, consumer, status_0, status_1,
    input  op_en_0, op_en_1, done_intr, err
  );

  modport slave (
    input  producer, op_en_wr, op_en_wdata, dp_done,
    output dp_op_start, dp_busy, consumer, status_0, status_1,
    output op_en_0, op_en_1, done_intr, err
  );
`endif

endinterface

// File: rtl/cmac_reg_group_ctrl.sv
// Ping-pong register-group scheduler for the CMAC layer configuration.
// Owns the consumer pointer and the per-group op_en flops, derives the
// per-group status readback, launches the datapath on the enabled consumer
// group and retires it when the datapath reports done.
// Build option: CMAC_GRP_PERF_EN adds a saturating per-layer cycle counter
// and the perf_cycles output.
module cmac_reg_group_ctrl (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  cmac_reg_group_ctrl_if.slave  grp
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] STAT_IDLE    = 2'd0;
  localparam logic [1:0] STAT_RUNNING = 2'd1;
  localparam logic [1:0] STAT_PENDING = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       consumer;
  logic       op_en_0;
  logic       op_en_1;
  logic       err_q;

  logic       cur_op_en;
  logic       prod_op_en;
  logic       prod_running;
  logic       wr_legal;
  logic       wr_illegal;
  logic       done_illegal;
  logic       retire;

  // A group counts as RUNNING whenever it is enabled and the consumer points
  // at it, so writes to it are refused from the moment it is armed until
  // the retire edge, including the DONE cycle itself.
  always_comb begin
    cur_op_en    = consumer ? op_en_1 : op_en_0;
    prod_op_en   = grp.producer ? op_en_1 : op_en_0;
    prod_running = prod_op_en && (grp.producer == consumer);
    wr_legal     = grp.op_en_wr && !prod_running;
    wr_illegal   = grp.op_en_wr && prod_running;
    done_illegal = grp.dp_done && (state != ST_BUSY);
    retire       = (state == ST_DONE);
  end

  // Layer sequencing: wait for the consumer group to be enabled, pulse the
  // launch, wait for the datapath, then spend one cycle retiring.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cur_op_en) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_BUSY;
      ST_BUSY:   if (grp.dp_done) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight layer without a done_intr.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The consumer pointer flips to the other group on the retire edge.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      consumer <= 1'b0;
    end else if (retire) begin
      consumer <= ~consumer;
    end
  end

  // Group 0 enable: cleared on its own retirement, otherwise follows legal
  // software writes. A legal write can never target the retiring group.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_0 <= 1'b0;
    end else if (retire && !consumer) begin
      op_en_0 <= 1'b0;
    end else if (wr_legal && !grp.producer) begin
      op_en_0 <= grp.op_en_wdata;
    end
  end

  // Group 1 enable: same rules as group 0.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_1 <= 1'b0;
    end else if (retire && consumer) begin
      op_en_1 <= 1'b0;
    end else if (wr_legal && grp.producer) begin
      op_en_1 <= grp.op_en_wdata;
    end
  end

  // Illegal writes and stray dp_done pulses share one registered error
  // pulse, so coincident events report once.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wr_illegal | done_illegal;
    end
  end

`ifdef CMAC_GRP_PERF_EN
  logic [31:0] perf_cnt;
  logic [31:0] perf_cycles_q;

  // Count LAUNCH and BUSY cycles with saturation; the DONE cycle itself is
  // included by latching count+1, after which the counter restarts.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_cnt      <= 32'd0;
      perf_cycles_q <= 32'd0;
    end else if (state == ST_DONE) begin
      perf_cycles_q <= (perf_cnt == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : perf_cnt + 32'd1;
      perf_cnt      <= 32'd0;
    end else if ((state == ST_LAUNCH || state == ST_BUSY) && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign grp.perf_cycles = perf_cycles_q;
`endif

  // Outputs decode straight from flops; nothing flows combinationally from
  // the inputs to the outputs.
  always_comb begin
    grp.dp_op_start = (state == ST_LAUNCH);
    grp.dp_busy     = (state != ST_IDLE);
    grp.consumer    = consumer;
    grp.op_en_0     = op_en_0;
    grp.op_en_1     = op_en_1;
    grp.err         = err_q;
    grp.done_intr   = {retire && consumer, retire && !consumer};
    grp.status_0    = !op_en_0 ? STAT_IDLE : (!consumer ? STAT_RUNNING : STAT_PENDING);
    grp.status_1    = !op_en_1 ? STAT_IDLE : (consumer ? STAT_RUNNING : STAT_PENDING);
  end

endmodule

// File: doc/cmac_reg_group_ctrl.md
# cmac_reg_group_ctrl

Ping-pong register-group scheduler for the CMAC layer configuration. It owns the consumer pointer and the per-group op_en bits. It derives the per-group status fields read back through the CMAC single register block. It launches the MAC datapath on the enabled consumer group and retires that group when the datapath reports done.

## Interface
- No parameters.
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  reset: asynchronous, active-low.
- producer  in  1  group currently addressed by software (from the single register block).
- op_en_wr  in  1  one-cycle pulse: software write to the op_en field of group `producer`.
- op_en_wdata  in  1  written op_en value.
- dp_done  in  1  one-cycle pulse: datapath finished the running layer.
- dp_op_start  out  1  one-cycle launch pulse to the datapath.
- dp_busy  out  1  high from launch until retirement.
- consumer  out  1  group the datapath executes next or now.
- status_0, status_1  out  2 each  group status: 0 IDLE, 1 RUNNING, 2 PENDING (3 never driven).
- op_en_0, op_en_1  out  1 each  group enable flops.
- done_intr  out  2  bit g pulses one cycle when group g retires.
- err  out  1  one-cycle pulse on illegal event.
- perf_cycles  out  32  last layer cycle count (present only with CMAC_GRP_PERF_EN).

## Operation
- FSM states: IDLE, LAUNCH, BUSY, DONE. Reset state is IDLE.
- IDLE goes to LAUNCH when op_en[consumer]=1. LAUNCH always goes to BUSY. BUSY goes to DONE on dp_done. DONE always goes to IDLE.
- dp_op_start = (state==LAUNCH). dp_busy = state in {LAUNCH, BUSY, DONE}.
- DONE cycle: done_intr[consumer]=1. On the following edge, op_en[consumer] clears and consumer toggles.
- Status per group g: IDLE if !op_en_g. RUNNING if op_en_g && consumer==g. PENDING otherwise. Status is combinational from the flops.
- op_en write to group g = producer:
  - If status_g is IDLE or PENDING, op_en_g <= op_en_wdata. Writing 0 to a PENDING group cancels it.
  - If status_g is RUNNING, the write is ignored and err pulses.
- dp_done outside BUSY is ignored and err pulses. A write and an illegal dp_done in the same cycle produce a single err pulse.
- A write in the DONE cycle targets a group that is still RUNNING, so it is ignored with err. Software must wait for done_intr.
- Reset mid-operation: every flop returns to its reset value immediately. An in-flight layer is abandoned with no done_intr.
- Reset values: consumer=0, op_en_0=op_en_1=0, status_0=status_1=0, dp_op_start=0, dp_busy=0, done_intr=0, err=0, perf_cycles=0.

## Timing
- op_en write in cycle N: op_en_g=1 in N+1. If g==consumer and the FSM is IDLE, dp_op_start is high in N+2.
- dp_done in cycle M: done_intr in M+1. Consumer toggles and the retired op_en reads 0 in M+2.
- A pending other group launches back-to-back: dp_op_start in M+3.
- Minimum layer occupancy is 4 cycles (LAUNCH, 1 BUSY, DONE, IDLE).
- All outputs except status are registered or decoded directly from state flops. No combinational path runs from inputs to outputs.

## Configuration
- CMAC_GRP_PERF_EN defined: a 32-bit counter increments every cycle in LAUNCH or BUSY and saturates at 0xFFFFFFFF. In DONE the counter value plus 1 is latched into perf_cycles and the counter clears. perf_cycles holds until the next DONE.
- CMAC_GRP_PERF_EN undefined: the counter and the perf_cycles port are absent. All other behaviour is identical.

## Test plan
- Reset, then producer=0, op_en_wr=1, op_en_wdata=1 at cycle 10: status_0=1 at 11, dp_op_start at 12. dp_done at 20: done_intr=2'b01 at 21, consumer=1 and status_0=0 at 22.
- Program group 0, then group 1 while group 0 is busy: status_1=2 (PENDING). After group 0 done, group 1 launches 3 cycles after dp_done and status_1 becomes 1.
- Write op_en_wdata=0 to PENDING group 1: op_en_1=0, status_1=0, no launch after group 0 retires, no err.
- Write to the RUNNING group, and dp_done while IDLE: each produces exactly one err pulse with no state change.
- Assert rstn low while BUSY: all outputs are 0 asynchronously and no done_intr appears after release.
- With CMAC_GRP_PERF_EN: dp_done 5 cycles after dp_op_start gives perf_cycles=7 one cycle after done_intr. A forced counter at 0xFFFFFFFF stays saturated.
